// File: rtl/pwm_seq_ctrl.sv
// pwm_seq_ctrl: steps a {period, duty, repeat} profile table on PWM period matches,
// presenting each entry to the PWM cfg0 hardware-update path with a one-cycle cfg_up strobe.
// Optional feature macro: PWM_SEQ_DITHER_EN adds per-entry duty dithering (dc / dc+1 alternation).
module pwm_seq_ctrl #(
  parameter int N = 16,
  parameter int DEPTH = 8,
  parameter int RPT_W = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             pwm_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  input  logic [LW-1:0]    seq_len,
  input  logic             prog_we,
`ifdef PWM_SEQ_DITHER_EN
  input  logic [AW:0]      prog_addr,
  input  logic             dither_en,
`else
  input  logic [AW-1:0]    prog_addr,
`endif
  input  logic [N-1:0]     prog_pr,
  input  logic [N-1:0]     prog_dc,
  input  logic [RPT_W-1:0] prog_rpt,
  input  logic             pr_match_event,
  output logic [N-1:0]     cfg_pr,
  output logic [N-1:0]     cfg_dc,
  output logic             cfg_up,
  output logic [AW-1:0]    cur_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [LW-1:0]    len_q, len_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [N-1:0]     cfg_pr_q, cfg_pr_d;
  logic [N-1:0]     cfg_dc_q, cfg_dc_d;
  logic             cfg_up_q, cfg_up_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ld;
  logic [LW-1:0]    eff_len;
  logic [AW-1:0]    wa;

  logic [N-1:0]     tbl_pr_q [DEPTH];
  logic [N-1:0]     tbl_dc_q [DEPTH];
  logic [RPT_W-1:0] tbl_rp_q [DEPTH];

`ifdef PWM_SEQ_DITHER_EN
  logic             tbl_dith_q [DEPTH];
  logic             ph_q, ph_d;
  logic             dith;
  logic [N-1:0]     dc_inc;
  assign dc_inc = (tbl_dc_q[idx_q] >= tbl_pr_q[idx_q]) ? tbl_pr_q[idx_q] : tbl_dc_q[idx_q] + 1'b1;
`endif

  assign wa      = prog_addr[AW-1:0];
  assign eff_len = (seq_len == '0) ? LW'(1) : (seq_len > LW'(DEPTH)) ? LW'(DEPTH) : seq_len;

  // Table write port: only while idle, so a running profile never changes under the sequencer
  always_ff @(posedge pwm_clk) begin
`ifdef PWM_SEQ_DITHER_EN
    if (prog_we && !busy_q && prog_addr[AW]) tbl_dith_q[wa] <= prog_dc[0];
    else if (prog_we && !busy_q) begin
`else
    if (prog_we && !busy_q) begin
`endif
      tbl_pr_q[wa] <= prog_pr;
      tbl_dc_q[wa] <= prog_dc;
      tbl_rp_q[wa] <= prog_rpt;
    end
  end

  // Next state and load decision; stop overrides start and match events
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    rpt_d   = rpt_q;
    ld      = 1'b0;
`ifdef PWM_SEQ_DITHER_EN
    dith    = 1'b0;
`endif
    if (stop) state_d = IDLE;
    else case (state_q)
      IDLE, FIN: begin
        state_d = start ? LOAD : IDLE;
        ld      = start;
        idx_d   = start ? '0 : idx_q;
        len_d   = start ? eff_len : len_q;
      end
      LOAD: state_d = RUN;
      RUN: if (pr_match_event) begin
        if (rpt_q != '0) begin
          rpt_d = rpt_q - 1'b1;
`ifdef PWM_SEQ_DITHER_EN
          dith  = dither_en && tbl_dith_q[idx_q];
`endif
        end else if ({1'b0, idx_q} + 1'b1 < len_q) begin
          idx_d   = idx_q + 1'b1;
          ld      = 1'b1;
          state_d = LOAD;
        end else if (loop_en) begin
          idx_d   = '0;
          ld      = 1'b1;
          state_d = LOAD;
        end else state_d = FIN;
      end
      default: state_d = IDLE;
    endcase
    rpt_d    = ld ? tbl_rp_q[idx_d] : rpt_d;
    cfg_pr_d = ld ? tbl_pr_q[idx_d] : cfg_pr_q;
    cfg_dc_d = ld ? tbl_dc_q[idx_d] : cfg_dc_q;
    cfg_up_d = ld;
`ifdef PWM_SEQ_DITHER_EN
    ph_d     = ld ? 1'b0 : ph_q ^ dith;
    cfg_dc_d = ld ? tbl_dc_q[idx_d] : dith ? (ph_q ? tbl_dc_q[idx_q] : dc_inc) : cfg_dc_q;
    cfg_up_d = ld | dith;
`endif
    busy_d   = (state_d == LOAD) || (state_d == RUN);
    done_d   = state_d == FIN;
  end

  // Sequencer state and registered outputs
  always_ff @(posedge pwm_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      rpt_q    <= '0;
      cfg_pr_q <= '0;
      cfg_dc_q <= '0;
      cfg_up_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PWM_SEQ_DITHER_EN
      ph_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      rpt_q    <= rpt_d;
      cfg_pr_q <= cfg_pr_d;
      cfg_dc_q <= cfg_dc_d;
      cfg_up_q <= cfg_up_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PWM_SEQ_DITHER_EN
      ph_q     <= ph_d;
`endif
    end
  end

  assign cfg_pr  = cfg_pr_q;
  assign cfg_dc  = cfg_dc_q;
  assign cfg_up  = cfg_up_q;
  assign cur_idx = idx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// tb_pwm_seq_ctrl: directed and randomized checks of pwm_seq_ctrl against an entry/period-count model
module tb_pwm_seq_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, loop_en = 1'b0, prog_we = 1'b0, pme = 1'b0;
  logic [3:0]  seq_len = 4'd3;
  logic [2:0]  prog_addr = 3'd0;
  logic [15:0] prog_pr = 16'd0, prog_dc = 16'd0;
  logic [7:0]  prog_rpt = 8'd0;
  logic [15:0] cfg_pr, cfg_dc;
  logic        cfg_up, busy, done;
  logic [2:0]  cur_idx;

  int checks = 0;
  int errors = 0;

  pwm_seq_ctrl dut (
    .pwm_clk(clk), .sys_rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .seq_len(seq_len), .prog_we(prog_we), .prog_addr(prog_addr), .prog_pr(prog_pr),
    .prog_dc(prog_dc), .prog_rpt(prog_rpt), .pr_match_event(pme), .cfg_pr(cfg_pr),
    .cfg_dc(cfg_dc), .cfg_up(cfg_up), .cur_idx(cur_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Model: a running entry lasts (rpt+1) match events counted since it was presented;
  // the presentation cycle itself ignores events.
  typedef struct packed {
    logic [15:0] e_pr;
    logic [15:0] e_dc;
    logic        e_up;
    logic        e_done;
    logic        busy;
    logic        fresh;
    int          idx;
    int          seen;
    int          len;
  } model_t;

  model_t      m = '0;
  logic [15:0] t_pr [DEPTH];
  logic [15:0] t_dc [DEPTH];
  logic [7:0]  t_rp [DEPTH];

  function automatic model_t present(model_t s, int i);
    model_t n = s;
    n.idx   = i;
    n.e_pr  = t_pr[i];
    n.e_dc  = t_dc[i];
    n.e_up  = 1'b1;
    n.seen  = 0;
    n.busy  = 1'b1;
    n.fresh = 1'b1;
    return n;
  endfunction

  function automatic model_t step(model_t s);
    model_t n = s;
    n.e_up   = 1'b0;
    n.e_done = 1'b0;
    n.fresh  = 1'b0;
    if (stop) n.busy = 1'b0;
    else if (!s.busy) begin
      if (start) begin
        n.len = (seq_len == 4'd0) ? 1 : (int'(seq_len) > DEPTH ? DEPTH : int'(seq_len));
        n = present(n, 0);
      end
    end else if (!s.fresh && pme) begin
      n.seen = s.seen + 1;
      if (n.seen > int'(t_rp[s.idx])) begin
        if (s.idx + 1 < n.len) n = present(n, s.idx + 1);
        else if (loop_en) n = present(n, 0);
        else begin
          n.busy   = 1'b0;
          n.e_done = 1'b1;
        end
      end
    end
    return n;
  endfunction

  // Model update on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else begin
      m <= step(m);
      if (prog_we && !m.busy) begin
        t_pr[prog_addr] <= prog_pr;
        t_dc[prog_addr] <= prog_dc;
        t_rp[prog_addr] <= prog_rpt;
      end
    end
  end

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    cmp("m_cfg_pr", 32'(cfg_pr), 32'(m.e_pr));
    cmp("m_cfg_dc", 32'(cfg_dc), 32'(m.e_dc));
    cmp("m_cfg_up", 32'(cfg_up), 32'(m.e_up));
    cmp("m_cur_idx", 32'(cur_idx), 32'(m.idx));
    cmp("m_busy", 32'(busy), 32'(m.busy));
    cmp("m_done", 32'(done), 32'(m.e_done));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic prog(int a, int pr, int dc, int rp);
    prog_we = 1'b1; prog_addr = 3'(a); prog_pr = 16'(pr); prog_dc = 16'(dc); prog_rpt = 8'(rp);
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_pme();
    pme = 1'b1; tick(); pme = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic prog_base();
    prog(0, 100, 50, 0);
    prog(1, 200, 20, 1);
    prog(2, 50, 10, 0);
  endtask

  initial begin
    tick(); tick();
    cmp("rst_cfg_pr", 32'(cfg_pr), 0);
    cmp("rst_cfg_up", 32'(cfg_up), 0);
    cmp("rst_busy", 32'(busy), 0);
    cmp("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick();
    prog_base();
    for (int i = 3; i < DEPTH; i++) prog(i, 300 + 10 * i, 7 * i, 0);

    // Basic three-entry run, no loop
    seq_len = 4'd3; loop_en = 1'b0;
    pulse_start();
    cmp("t1_up0", 32'(cfg_up), 1); cmp("t1_pr0", 32'(cfg_pr), 100);
    cmp("t1_dc0", 32'(cfg_dc), 50); cmp("t1_busy0", 32'(busy), 1);
    tick();
    pulse_pme();
    cmp("t1_up1", 32'(cfg_up), 1); cmp("t1_pr1", 32'(cfg_pr), 200);
    cmp("t1_dc1", 32'(cfg_dc), 20); cmp("t1_idx1", 32'(cur_idx), 1);
    tick();
    pulse_pme();
    cmp("t1_rpt_noup", 32'(cfg_up), 0);
    pulse_pme();
    cmp("t1_up2", 32'(cfg_up), 1); cmp("t1_pr2", 32'(cfg_pr), 50);
    cmp("t1_dc2", 32'(cfg_dc), 10);
    tick();
    pulse_pme();
    cmp("t1_done", 32'(done), 1); cmp("t1_busy_end", 32'(busy), 0);
    tick();
    cmp("t1_done_pulse", 32'(done), 0);

    // Same with loop: wraps back to entry 0
    loop_en = 1'b1;
    pulse_start(); tick();
    pulse_pme(); tick();
    pulse_pme(); pulse_pme(); tick();
    pulse_pme();
    cmp("t2_wrap_up", 32'(cfg_up), 1); cmp("t2_wrap_pr", 32'(cfg_pr), 100);
    cmp("t2_wrap_idx", 32'(cur_idx), 0); cmp("t2_wrap_busy", 32'(busy), 1);
    pulse_stop();
    loop_en = 1'b0;

    // stop together with a loading match event
    pulse_start(); tick();
    pulse_pme(); tick();
    pulse_pme();
    stop = 1'b1; pme = 1'b1; tick(); stop = 1'b0; pme = 1'b0;
    cmp("t3_noup", 32'(cfg_up), 0); cmp("t3_nodone", 32'(done), 0);
    cmp("t3_busy", 32'(busy), 0); cmp("t3_pr_hold", 32'(cfg_pr), 200);
    cmp("t3_dc_hold", 32'(cfg_dc), 20);
    tick();
    cmp("t3_nodone2", 32'(done), 0);

    // Writes dropped and start ignored while busy
    pulse_start(); tick();
    prog(1, 999, 99, 3);
    pulse_pme();
    cmp("t4_pr_kept", 32'(cfg_pr), 200); cmp("t4_dc_kept", 32'(cfg_dc), 20);
    tick();
    pulse_start();
    cmp("t4_start_ign_idx", 32'(cur_idx), 1); cmp("t4_start_ign_up", 32'(cfg_up), 0);
    pulse_stop();

    // seq_len 0 means one entry
    seq_len = 4'd0;
    pulse_start(); tick();
    pulse_pme();
    cmp("t5_len0_done", 32'(done), 1); cmp("t5_len0_idx", 32'(cur_idx), 0);

    // seq_len above DEPTH clamps to DEPTH
    seq_len = 4'd15;
    pulse_start(); tick();
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (i == 1) pulse_pme();
      pulse_pme();
      cmp("t5_clamp_idx", 32'(cur_idx), 32'(i + 1));
      tick();
    end
    pulse_pme();
    cmp("t5_clamp_done", 32'(done), 1);
    tick();

    // Asynchronous reset mid-run
    seq_len = 4'd3;
    pulse_start(); tick();
    pulse_pme(); tick();
    #2 rst_n = 1'b0;
    #1;
    cmp("t6_pr", 32'(cfg_pr), 0); cmp("t6_dc", 32'(cfg_dc), 0);
    cmp("t6_up", 32'(cfg_up), 0); cmp("t6_idx", 32'(cur_idx), 0);
    cmp("t6_busy", 32'(busy), 0); cmp("t6_done", 32'(done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    prog_base();
    pulse_start();
    cmp("t6_restart_idx", 32'(cur_idx), 0); cmp("t6_restart_pr", 32'(cfg_pr), 100);
    cmp("t6_restart_up", 32'(cfg_up), 1);
    pulse_stop();

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 4000; c++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      pme   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) loop_en = 1'($urandom_range(0, 1));
      seq_len   = 4'($urandom_range(0, 15));
      prog_we   = ($urandom_range(0, 9) == 0);
      prog_addr = 3'($urandom_range(0, 7));
      prog_pr   = 16'($urandom);
      prog_dc   = 16'($urandom);
      prog_rpt  = 8'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0; stop = 1'b0; pme = 1'b0; prog_we = 1'b0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
